// File: rtl/ddr3_arb_pkg.sv
// Shared types and default widths for the two-port DDR3 burst arbiter.
// Contents:
//   arb_state_e   - controller state encoding
//   DEF_*         - default widths matching the slowDDR3 sysIO user port
package ddr3_arb_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 27;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/ddr3_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker (purely combinational).
// Ports:
//   req        in  2  request bits, bit i = requester i
//   last_grant in  1  index of the requester served most recently
//   gnt_idx    out 1  chosen requester (meaningful when gnt_any = 1)
//   gnt_any    out 1  at least one request is pending
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx,
  output logic       gnt_any
);

  always_comb begin
    gnt_any = |req;
    // On a tie the requester that was not served last wins; otherwise
    // the lone requester (or 0 when idle) is reported.
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Two-port burst arbiter in front of the single slowDDR3 user port.
// Each port issues a burst command (read/write, start address, len = beats-1,
// sel) and then streams beats over its own valid/ready channel. One burst is
// granted at a time, round-robin; per-beat addresses are generated here and
// data handshakes are steered to the owning port.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   p_cmd_*                     per-port burst command channel (2 lanes)
//   p_wr_*                      per-port write beat channel
//   p_rd_valid/ready            per-port read beat handshake
//   p_rd_payload                read data shared by both ports
//   ddr_*                       slowDDR3 sysIO user port
//   grant                       owning port index (valid while busy)
//   busy                        high while a burst is in progress
//
// state | meaning
// INIT  | waiting for ddr_init_fin; no commands accepted
// ARB   | picking the next burst; p_cmd_ready offered to the winner
// WRITE | streaming write beats from port grant to the DDR port
// READ  | streaming read beats from the DDR port to port grant
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            p_cmd_valid,
  output logic [1:0]            p_cmd_ready,
  input  logic [1:0]            p_cmd_write,
  input  logic [2*ADDR_W-1:0]   p_cmd_addr,
  input  logic [2*LEN_W-1:0]    p_cmd_len,
  input  logic [2*SEL_W-1:0]    p_cmd_sel,
  input  logic [1:0]            p_wr_valid,
  output logic [1:0]            p_wr_ready,
  input  logic [2*DATA_W-1:0]   p_wr_payload,
  output logic [1:0]            p_rd_valid,
  input  logic [1:0]            p_rd_ready,
  output logic [DATA_W-1:0]     p_rd_payload,
  output logic [ADDR_W-1:0]     ddr_address,
  output logic [SEL_W-1:0]      ddr_sel,
  output logic                  ddr_wr_valid,
  input  logic                  ddr_wr_ready,
  output logic [DATA_W-1:0]     ddr_wr_payload,
  input  logic                  ddr_rd_valid,
  output logic                  ddr_rd_ready,
  input  logic [DATA_W-1:0]     ddr_rd_payload,
  input  logic                  ddr_init_fin,
  output logic                  grant,
  output logic                  busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  CNT_ONE  = 1;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic                arb_idx;
  logic                arb_any;
  logic                beat_fire;

  rr_arb2 u_rr_arb2 (
    .req        (p_cmd_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // Data-path steering: combinational, so a beat can fire in the first
  // cycle after the command is accepted.
  always_comb begin
    p_cmd_ready    = 2'b00;
    p_wr_ready     = 2'b00;
    p_rd_valid     = 2'b00;
    ddr_wr_valid   = 1'b0;
    ddr_rd_ready   = 1'b0;
    p_rd_payload   = ddr_rd_payload;
    ddr_wr_payload = grant_q ? p_wr_payload[2*DATA_W-1:DATA_W] : p_wr_payload[DATA_W-1:0];
    unique case (state_q)
      INIT: ;
      ARB: begin
        p_cmd_ready[arb_idx] = arb_any;
      end
      WRITE: begin
        ddr_wr_valid        = p_wr_valid[grant_q];
        p_wr_ready[grant_q] = ddr_wr_ready;
      end
      READ: begin
        p_rd_valid[grant_q] = ddr_rd_valid;
        ddr_rd_ready        = p_rd_ready[grant_q];
      end
    endcase
    beat_fire = (ddr_wr_valid & ddr_wr_ready) | (ddr_rd_valid & ddr_rd_ready);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      INIT: begin
        if (ddr_init_fin) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (arb_any) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          addr_d       = arb_idx ? p_cmd_addr[2*ADDR_W-1:ADDR_W] : p_cmd_addr[ADDR_W-1:0];
          len_d        = arb_idx ? p_cmd_len[2*LEN_W-1:LEN_W]    : p_cmd_len[LEN_W-1:0];
          sel_d        = arb_idx ? p_cmd_sel[2*SEL_W-1:SEL_W]    : p_cmd_sel[SEL_W-1:0];
          cnt_d        = '0;
          state_d      = p_cmd_write[arb_idx] ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (beat_fire) begin
          // Address wraps naturally at 2^ADDR_W.
          addr_d = addr_q + ADDR_ONE;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == len_q) begin
            state_d = ARB;
          end
        end
      end
    endcase
    busy_d = (state_d == WRITE) || (state_d == READ);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= INIT;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      sel_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign ddr_address = addr_q;
  assign ddr_sel     = sel_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter: every accepted command pushes the
// beats it should produce; a negedge monitor pops and compares them as beats
// fire on the DDR side (writes) or on the port side (reads).
module tb_ddr3_port_arbiter;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
  localparam int LEN_W  = 8;

  logic                clk;
  logic                resetn;
  logic [1:0]          p_cmd_valid;
  logic [1:0]          p_cmd_ready;
  logic [1:0]          p_cmd_write;
  logic [2*ADDR_W-1:0] p_cmd_addr;
  logic [2*LEN_W-1:0]  p_cmd_len;
  logic [2*SEL_W-1:0]  p_cmd_sel;
  logic [1:0]          p_wr_valid;
  logic [1:0]          p_wr_ready;
  logic [2*DATA_W-1:0] p_wr_payload;
  logic [1:0]          p_rd_valid;
  logic [1:0]          p_rd_ready;
  logic [DATA_W-1:0]   p_rd_payload;
  logic [ADDR_W-1:0]   ddr_address;
  logic [SEL_W-1:0]    ddr_sel;
  logic                ddr_wr_valid;
  logic                ddr_wr_ready;
  logic [DATA_W-1:0]   ddr_wr_payload;
  logic                ddr_rd_valid;
  logic                ddr_rd_ready;
  logic [DATA_W-1:0]   ddr_rd_payload;
  logic                ddr_init_fin;
  logic                grant;
  logic                busy;

  typedef struct {
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } beat_t;

  beat_t wr_q[$];
  beat_t rd_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;

  ddr3_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .LEN_W(LEN_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .p_cmd_valid    (p_cmd_valid),
    .p_cmd_ready    (p_cmd_ready),
    .p_cmd_write    (p_cmd_write),
    .p_cmd_addr     (p_cmd_addr),
    .p_cmd_len      (p_cmd_len),
    .p_cmd_sel      (p_cmd_sel),
    .p_wr_valid     (p_wr_valid),
    .p_wr_ready     (p_wr_ready),
    .p_wr_payload   (p_wr_payload),
    .p_rd_valid     (p_rd_valid),
    .p_rd_ready     (p_rd_ready),
    .p_rd_payload   (p_rd_payload),
    .ddr_address    (ddr_address),
    .ddr_sel        (ddr_sel),
    .ddr_wr_valid   (ddr_wr_valid),
    .ddr_wr_ready   (ddr_wr_ready),
    .ddr_wr_payload (ddr_wr_payload),
    .ddr_rd_valid   (ddr_rd_valid),
    .ddr_rd_ready   (ddr_rd_ready),
    .ddr_rd_payload (ddr_rd_payload),
    .ddr_init_fin   (ddr_init_fin),
    .grant          (grant),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DATA_W-1:0] rd_word(logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DATA_W-1:0] wr_word(int port, logic [ADDR_W-1:0] a);
    return a[15:0] ^ ((port == 1) ? 16'hC300 : 16'h0C00);
  endfunction

  // Memory model: read data is a fixed function of the presented address.
  assign ddr_rd_payload = rd_word(ddr_address);

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_beats(input int port, input bit wr, input logic [ADDR_W-1:0] addr,
                            input int len, input logic [SEL_W-1:0] sel);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.port = port;
      b.addr = addr + ADDR_W'(i);
      b.data = wr ? wr_word(port, b.addr) : rd_word(b.addr);
      b.sel  = sel;
      if (wr) wr_q.push_back(b);
      else    rd_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (ddr_wr_valid && ddr_wr_ready) begin
        if (wr_q.size() == 0) begin
          check_val("wr_unexpected_beat", 1, 0);
        end else begin
          mon_e = wr_q.pop_front();
          check_val("wr_addr",  ddr_address,    mon_e.addr);
          check_val("wr_data",  ddr_wr_payload, mon_e.data);
          check_val("wr_sel",   ddr_sel,        mon_e.sel);
          check_val("wr_grant", grant,          mon_e.port);
        end
      end
      if ((p_rd_valid & p_rd_ready) != 2'b00) begin
        if (rd_q.size() == 0) begin
          check_val("rd_unexpected_beat", 1, 0);
        end else begin
          mon_e = rd_q.pop_front();
          check_val("rd_port", p_rd_valid & p_rd_ready, 64'd1 << mon_e.port);
          check_val("rd_addr", ddr_address,  mon_e.addr);
          check_val("rd_data", p_rd_payload, mon_e.data);
          check_val("rd_sel",  ddr_sel,      mon_e.sel);
        end
      end
      if (busy) begin
        check_val("leak_wr_ready", p_wr_ready[~grant], 0);
        check_val("leak_rd_valid", p_rd_valid[~grant], 0);
      end
    end
  end

  task automatic set_cmd(input int port, input bit wr, input logic [ADDR_W-1:0] addr,
                         input int len, input logic [SEL_W-1:0] sel);
    p_cmd_write[port]                  = wr;
    p_cmd_addr[port*ADDR_W +: ADDR_W]  = addr;
    p_cmd_len[port*LEN_W +: LEN_W]     = LEN_W'(len);
    p_cmd_sel[port*SEL_W +: SEL_W]     = sel;
  endtask

  // Presents a command, waits for acceptance, pushes its beats.
  task automatic issue_cmd(input int port, input bit wr, input logic [ADDR_W-1:0] addr,
                           input int len, input logic [SEL_W-1:0] sel, output int waited);
    set_cmd(port, wr, addr, len, sel);
    p_cmd_valid[port] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!p_cmd_ready[port] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!p_cmd_ready[port]) begin
      check_val("cmd_accept_timeout", 0, 1);
      p_cmd_valid[port] = 1'b0;
      return;
    end
    check_val("cmd_ready_onehot", p_cmd_ready, 64'd1 << port);
    push_beats(port, wr, addr, len, sel);
    @(posedge clk); #1;
    p_cmd_valid[port] = 1'b0;
    check_val("busy_after_cmd", busy, 1);
    check_val("grant_after_cmd", grant, port);
  endtask

  // Streams len+1 write beats on port; the other port offers junk the whole time.
  task automatic stream_write(input int port, input logic [ADDR_W-1:0] addr, input int len);
    int other = 1 - port;
    for (int i = 0; i <= len; i++) begin
      logic [ADDR_W-1:0] a;
      int n;
      a = addr + ADDR_W'(i);
      p_wr_payload[port*DATA_W +: DATA_W]  = wr_word(port, a);
      p_wr_payload[other*DATA_W +: DATA_W] = 16'hBAD0;
      p_wr_valid = 2'b11;
      n = 0;
      @(negedge clk);
      while (!p_wr_ready[port] && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!p_wr_ready[port]) begin
        check_val("wr_beat_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    p_wr_valid = 2'b00;
  endtask

  task automatic stream_read(input int port, input int len, input bit toggle);
    int other = 1 - port;
    int got = 0;
    int c = 0;
    p_rd_ready[other] = 1'b1;
    while (got <= len && c < 200) begin
      p_rd_ready[port] = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      check_val("rd_ready_mirror", ddr_rd_ready, p_rd_ready[port]);
      if (p_rd_valid[port] && p_rd_ready[port]) got++;
      @(posedge clk); #1;
      c++;
    end
    if (got <= len) check_val("rd_beat_timeout", got, len + 1);
    p_rd_ready = 2'b00;
  endtask

  logic [ADDR_W-1:0] fa[2];
  logic [SEL_W-1:0]  fs[2];

  initial begin
    int waited;
    int viol;
    int g;
    int n;

    resetn       = 1'b0;
    ddr_init_fin = 1'b0;
    p_cmd_valid  = '0;
    p_cmd_write  = '0;
    p_cmd_addr   = '0;
    p_cmd_len    = '0;
    p_cmd_sel    = '0;
    p_wr_valid   = '0;
    p_wr_payload = '0;
    p_rd_ready   = '0;
    ddr_wr_ready = 1'b1;
    ddr_rd_valid = 1'b0;

    // Reset state
    #2;
    check_val("rst_busy",        busy,         0);
    check_val("rst_grant",       grant,        0);
    check_val("rst_address",     ddr_address,  0);
    check_val("rst_sel",         ddr_sel,      0);
    check_val("rst_cmd_ready",   p_cmd_ready,  0);
    check_val("rst_ddr_wr_valid", ddr_wr_valid, 0);
    check_val("rst_ddr_rd_ready", ddr_rd_ready, 0);
    check_val("rst_p_wr_ready",  p_wr_ready,   0);
    check_val("rst_p_rd_valid",  p_rd_valid,   0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Init gating, then single 4-beat write on port 0
    set_cmd(0, 1'b1, 27'h100, 3, 2'd1);
    p_cmd_valid = 2'b01;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (p_cmd_ready != 2'b00) viol++;
    end
    check_val("init_gate", viol, 0);
    @(posedge clk); #1;
    ddr_init_fin = 1'b1;
    issue_cmd(0, 1'b1, 27'h100, 3, 2'd1, waited);
    check_val("init_to_ready_cycles", waited, 1);
    stream_write(0, 27'h100, 3);
    check_val("single_wr_back_to_arb", busy, 0);
    check_val("single_wr_queue_empty", wr_q.size(), 0);

    // Read with port-side backpressure on port 1
    ddr_rd_valid = 1'b1;
    issue_cmd(1, 1'b0, 27'h20, 1, 2'd2, waited);
    stream_read(1, 1, 1'b1);
    ddr_rd_valid = 1'b0;
    check_val("rd_back_to_arb", busy, 0);
    check_val("rd_queue_empty", rd_q.size(), 0);

    // Tie and fairness: both ports request 2-beat writes continuously
    fa[0] = 27'h400; fs[0] = 2'd3;
    fa[1] = 27'h800; fs[1] = 2'd0;
    set_cmd(0, 1'b1, fa[0], 1, fs[0]);
    set_cmd(1, 1'b1, fa[1], 1, fs[1]);
    p_cmd_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [ADDR_W-1:0] a;
      n = 0;
      @(negedge clk);
      while (p_cmd_ready == 2'b00 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (p_cmd_ready == 2'b00) begin
        check_val("rr_accept_timeout", 0, 1);
        break;
      end
      g = p_cmd_ready[1] ? 1 : 0;
      check_val("rr_grant_seq", g, k % 2);
      a = fa[g];
      push_beats(g, 1'b1, a, 1, fs[g]);
      @(posedge clk); #1;
      check_val("rr_grant_reg", grant, g);
      fa[g] = fa[g] + 27'h10;
      set_cmd(g, 1'b1, fa[g], 1, fs[g]);
      if (k == 3) p_cmd_valid = 2'b00;
      stream_write(g, a, 1);
    end
    p_cmd_valid = 2'b00;
    check_val("rr_queue_empty", wr_q.size(), 0);

    // Address wrap at 2^27-1
    issue_cmd(0, 1'b1, 27'h7FFFFFF, 1, 2'd2, waited);
    stream_write(0, 27'h7FFFFFF, 1);
    check_val("wrap_queue_empty", wr_q.size(), 0);

    // Reset during beat 2 of an 8-beat read
    ddr_rd_valid = 1'b1;
    p_rd_ready   = 2'b11;
    issue_cmd(0, 1'b0, 27'h300, 7, 2'd1, waited);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check_val("mid_rst_busy",        busy,         0);
    check_val("mid_rst_grant",       grant,        0);
    check_val("mid_rst_address",     ddr_address,  0);
    check_val("mid_rst_sel",         ddr_sel,      0);
    check_val("mid_rst_p_rd_valid",  p_rd_valid,   0);
    check_val("mid_rst_ddr_rd_ready", ddr_rd_ready, 0);
    check_val("mid_rst_cmd_ready",   p_cmd_ready,  0);
    check_val("mid_rst_beats_left",  rd_q.size(),  7);
    rd_q.delete();
    ddr_init_fin = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || p_rd_valid != 2'b00 || ddr_rd_ready || p_cmd_ready != 2'b00) viol++;
    end
    @(posedge clk); #1;
    ddr_init_fin = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy || p_rd_valid != 2'b00 || ddr_rd_ready) viol++;
    end
    check_val("no_burst_resume", viol, 0);
    ddr_rd_valid = 1'b0;
    p_rd_ready   = 2'b00;

    // After reset port 0 wins a tie; single-beat (len = 0) burst
    @(posedge clk); #1;
    fa[0] = 27'h500; fs[0] = 2'd1;
    fa[1] = 27'h600; fs[1] = 2'd2;
    set_cmd(0, 1'b1, fa[0], 0, fs[0]);
    set_cmd(1, 1'b1, fa[1], 0, fs[1]);
    p_cmd_valid = 2'b11;
    n = 0;
    @(negedge clk);
    while (p_cmd_ready == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (p_cmd_ready == 2'b00) begin
      check_val("tie_accept_timeout", 0, 1);
      p_cmd_valid = 2'b00;
    end else begin
      g = p_cmd_ready[1] ? 1 : 0;
      check_val("post_rst_tie", g, 0);
      push_beats(g, 1'b1, fa[g], 0, fs[g]);
      @(posedge clk); #1;
      p_cmd_valid = 2'b00;
      stream_write(g, fa[g], 0);
      check_val("len0_back_to_arb", busy, 0);
    end

    repeat (3) @(negedge clk);
    check_val("final_wr_queue_empty", wr_q.size(), 0);
    check_val("final_rd_queue_empty", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr3_port_arbiter.md
Name: ddr3_port_arbiter

Overview:
- Two-port burst arbiter in front of the single slowDDR3 user port.
- Each requester issues a burst command (read or write, start address, length), then streams data over its own 16-bit valid/ready channel.
- The block grants one burst at a time with round-robin fairness.
- It generates the per-beat address that slowDDR3 needs, and steers the data handshakes to the granted port.

Parameters:
- ADDR_W, 27, word address width (matches sysIO_address)
- DATA_W, 16, beat width (matches sysIO_dataWr/Rd_payload)
- SEL_W, 2, sel width passed to sysIO_sel
- LEN_W, 8, burst length field width; burst is len+1 beats

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- p_cmd_valid  in  2  per-port command valid (bit i = port i)
- p_cmd_ready  out  2  per-port command accept
- p_cmd_write  in  2  1 = write burst, 0 = read burst
- p_cmd_addr  in  2*ADDR_W  start address; port i at [i*ADDR_W +: ADDR_W]
- p_cmd_len  in  2*LEN_W  beats minus one
- p_cmd_sel  in  2*SEL_W  sel value for the burst
- p_wr_valid  in  2  write beat valid
- p_wr_ready  out  2  write beat ready
- p_wr_payload  in  2*DATA_W  write data
- p_rd_valid  out  2  read beat valid
- p_rd_ready  in  2  read beat ready
- p_rd_payload  out  DATA_W  read data, shared by both ports; qualified by p_rd_valid
- ddr_address  out  ADDR_W  to sysIO_address
- ddr_sel  out  SEL_W  to sysIO_sel
- ddr_wr_valid  out  1  to sysIO_dataWr_valid
- ddr_wr_ready  in  1  from sysIO_dataWr_ready
- ddr_wr_payload  out  DATA_W  to sysIO_dataWr_payload
- ddr_rd_valid  in  1  from sysIO_dataRd_valid
- ddr_rd_ready  out  1  to sysIO_dataRd_ready
- ddr_rd_payload  in  DATA_W  from sysIO_dataRd_payload
- ddr_init_fin  in  1  from sysIO_initFin
- grant  out  1  index of the owning port (valid when busy = 1)
- busy  out  1  high in WRITE or READ

Behaviour:
- Reset (async, resetn = 0):
  - State = INIT, grant = 0, last_grant = 1 (so port 0 wins the first tie).
  - Address, sel and beat counter = 0.
  - All ready/valid outputs = 0.
  - Reset mid-burst aborts the burst immediately; no partial-state recovery.
- INIT: all p_cmd_ready = 0. When ddr_init_fin is sampled high -> ARB. ddr_init_fin is ignored outside INIT.
- ARB:
  - Pick from the asserted p_cmd_valid bits.
  - One valid: that port. Both valid: the port != last_grant.
  - p_cmd_ready[g] = 1 combinationally this cycle, only for the chosen port.
  - On the fire edge: latch addr, len, sel and write; set grant = g and last_grant = g.
  - Next state: WRITE if write = 1, else READ.
  - No valid: stay in ARB.
- Command accept latency: exactly 1 cycle from ARB fire to the first possible data beat.
- WRITE (combinational steering):
  - ddr_wr_valid = p_wr_valid[grant].
  - p_wr_ready[grant] = ddr_wr_ready; the other port's ready = 0.
  - ddr_wr_payload = slice grant of p_wr_payload.
  - ddr_rd_ready = 0.
- READ (combinational steering):
  - p_rd_valid[grant] = ddr_rd_valid; the other port's valid = 0.
  - ddr_rd_ready = p_rd_ready[grant].
  - p_rd_payload = ddr_rd_payload.
  - ddr_wr_valid = 0.
- Beat fire = downstream valid & ready in the active direction.
- On each beat:
  - Address increments by 1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - Beat counter increments.
- When the counter equals len and a beat fires: return to ARB on the next cycle. A burst of len = 0 is a single beat.
- ddr_address and ddr_sel are driven from registers and hold stable between beats. They keep their last values while in ARB or INIT.
- Requests on the non-granted port are held off (cmd_ready = 0) until the current burst ends. No preemption.
- A cmd_valid deassert before acceptance is legal; the arbiter re-evaluates every ARB cycle.
- Back-to-back bursts: minimum one ARB cycle between the last beat of one burst and the first beat of the next.

Decomposition:
- Package ddr3_arb_pkg:
  - state enum {INIT, ARB, WRITE, READ}.
  - Default widths ADDR_W, DATA_W, LEN_W, SEL_W.
- Sub-module rr_arb2: 2-requester round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_idx, gnt_any.
  - Purely combinational; last_grant stays a register in the top level.

Test Plan:
- Init gating: ddr_init_fin low for 50 cycles with p_cmd_valid = 2'b01 -> p_cmd_ready stays 0. Assert init_fin -> p_cmd_ready[0] = 1 on the next cycle.
- Single write: port 0, addr 0x100, len 3, ddr_wr_ready always 1 -> ddr_address = 0x100..0x103 across 4 beats, payload matches port 0 data, then state ARB.
- Tie and fairness: both ports request 2-beat writes continuously -> grant sequence 0, 1, 0, 1; no beats leak to the non-granted port.
- Read backpressure: port 1 reads addr 0x20, len 1; p_rd_ready[1] toggles 1/0 -> ddr_rd_ready mirrors it and the address advances only on fired beats (0x20 then 0x21).
- Address wrap: write at addr 2^27-1, len 1 -> beats at 0x7FFFFFF then 0x0000000.
- Reset mid-burst: assert resetn = 0 during beat 2 of an 8-beat read -> all outputs 0 immediately, state INIT; the burst is not resumed after init_fin returns.
